// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-only data memory.
// Sub-word stores are done as read-modify-write of the containing word.
`timescale 1ns/1ps
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            wr_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] data_q;
  logic            fault_q;

  logic            fault_c;
  logic            accept;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] load_val;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;

  assign accept = (state == S_IDLE) && req_valid;

  // Reserved size always faults; alignment only checked when enabled.
  always_comb begin
    fault_c = 1'b0;
    if (req_size == 2'b11) begin
      fault_c = 1'b1;
    end else if (CHECK_ALIGN) begin
      if (req_size == SZ_HALF && req_addr[0])
        fault_c = 1'b1;
      else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
        fault_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request capture and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        fault_q <= fault_c;
      end
      if (state == S_READ)
        data_q <= mem_rdata;
    end
  end

  // Store data merged into the captured word on little-endian lanes.
  always_comb begin
    merged = data_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      SZ_WORD: merged = wdata_q;
      default: merged = data_q;
    endcase
  end

  // Load extraction with optional sign extension.
  always_comb begin
    byte_val = data_q[{addr_q[1:0], 3'b000} +: 8];
    half_val = data_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_val = {{24{sgn_q & byte_val[7]}}, byte_val};
      SZ_HALF: load_val = {{16{sgn_q & half_val[15]}}, half_val};
      default: load_val = data_q;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: begin
        req_ready = ~reset;
        if (req_valid) begin
          if (fault_c)
            state_nxt = S_RESP;
          else if (req_write && req_size == SZ_WORD)
            state_nxt = S_WRITE;
          else
            state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        state_nxt = wr_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata = merged;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if (!wr_q && !fault_q)
          resp_rdata = load_val;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// word-array reference memory, for both alignment-check settings.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr, req_wdata;
  logic        v0, v1, sel;

  logic        rdy0, rv0, rf0, we0;
  logic [31:0] rd0, ma0, mw0, mr0;
  logic        rdy1, rv1, rf1, we1;
  logic [31:0] rd1, ma1, mw1, mr1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic        pre_we0, pre_we1;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  logic [31:0] ref_mem [0:1][0:255];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;
  bit          last_f;

  load_store_unit #(.CHECK_ALIGN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_fault(rf0), .mem_we(we0), .mem_addr(ma0),
    .mem_wdata(mw0), .mem_rdata(mr0)
  );

  load_store_unit #(.CHECK_ALIGN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_fault(rf1), .mem_we(we1), .mem_addr(ma1),
    .mem_wdata(mw1), .mem_rdata(mr1)
  );

  assign mr0 = mem0[ma0[9:2]];
  assign mr1 = mem1[ma1[9:2]];

  always @(posedge clk) begin
    if (we0) mem0[ma0[9:2]] <= mw0;
    if (pre_we0) mem0[pre_idx] <= pre_data;
    if (we1) mem1[ma1[9:2]] <= mw1;
    if (pre_we1) mem1[pre_idx] <= pre_data;
  end

  logic        rdy_m, rv_m, rf_m, we_m;
  logic [31:0] rd_m, ma_m, mw_m;
  assign rdy_m = sel ? rdy1 : rdy0;
  assign rv_m  = sel ? rv1  : rv0;
  assign rf_m  = sel ? rf1  : rf0;
  assign we_m  = sel ? we1  : we0;
  assign rd_m  = sel ? rd1  : rd0;
  assign ma_m  = sel ? ma1  : ma0;
  assign mw_m  = sel ? mw1  : mw0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_fault(input bit align, input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (!align) return 1'b0;
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sg, input logic [31:0] a);
    logic [31:0] v;
    int sh;
    v = w;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
    int sh;
    if (sz == 2'd2) return wd;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return w;
  endfunction

  task automatic preload(input int s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_idx  = a[9:2];
    pre_data = d;
    if (s == 0) pre_we0 = 1'b1; else pre_we1 = 1'b1;
    @(posedge clk);
    #1;
    pre_we0 = 1'b0;
    pre_we1 = 1'b0;
    ref_mem[s][int'(a[9:2])] = d;
  endtask

  // One request through the selected unit, checked against the reference model.
  task automatic do_req(input int s, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int idx, exp_lat, lat, nwe;
    bit exp_f, exp_w, got_f;
    logic [31:0] old, exp_rd, nw, wa, wdv, got_rd, mem_now;
    idx     = int'(a[9:2]);
    old     = ref_mem[s][idx];
    exp_f   = ref_fault(s == 0, sz, a);
    exp_w   = wr && !exp_f;
    nw      = ref_store(old, sz, a, wd);
    exp_rd  = (wr || exp_f) ? 32'h0 : ref_load(old, sz, sg, a);
    exp_lat = exp_f ? 1 : ((wr && sz != 2'd2) ? 3 : 2);
    @(negedge clk);
    sel = (s != 0);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    if (s == 0) v0 = 1'b1; else v1 = 1'b1;
    #1 chk("accept_ready", 32'(rdy_m), 32'h1);
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nwe = 0; wa = 0; wdv = 0; got_rd = 0; got_f = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (we_m) begin nwe++; wa = ma_m; wdv = mw_m; end
      if (rv_m) begin lat = n; got_rd = rd_m; got_f = rf_m; break; end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("fault", 32'(got_f), 32'(exp_f));
    chk("rdata", got_rd, exp_rd);
    chk("write_count", 32'(nwe), 32'(exp_w));
    if (exp_w) begin
      chk("write_addr", wa, a & ~32'h3);
      chk("write_data", wdv, nw);
      ref_mem[s][idx] = nw;
    end
    @(negedge clk);
    chk("idle_ready", 32'(rdy_m), 32'h1);
    chk("idle_valid", 32'(rv_m), 32'h0);
    chk("idle_rdata", rd_m, 32'h0);
    mem_now = (s == 0) ? mem0[idx] : mem1[idx];
    chk("mem_word", mem_now, ref_mem[s][idx]);
    last_rd = got_rd;
    last_f  = got_f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, nresp, nrdy, bad;
    int rt [3];
    logic [31:0] rdat [3];
    bit take;

    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; sel = 1'b0;
    pre_we0 = 1'b0; pre_we1 = 1'b0; pre_idx = '0; pre_data = '0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'h0);
    chk("rst_valid", 32'(rv0), 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_fault", 32'(rf0), 32'h0);
    chk("rst_we", 32'(we0), 32'h0);
    chk("rst_addr", ma0, 32'h0);
    chk("rst_wdata", mw0, 32'h0);
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(rdy0), 32'h1);

    // Word store then word load.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("sw10_mem", mem0[4], 32'hDEAD_BEEF);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw10", last_rd, 32'hDEAD_BEEF);

    // Byte store read-modify-write.
    preload(0, 32'h20, 32'h1122_3344);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AB);
    chk("sb22_mem", mem0[8], 32'h11AB_3344);

    // Sub-word loads with extension.
    preload(0, 32'h30, 32'h80FF_7F01);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h33, 32'h0);
    chk("lb33", last_rd, 32'hFFFF_FF80);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h33, 32'h0);
    chk("lbu33", last_rd, 32'h0000_0080);
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h30, 32'h0);
    chk("lh30", last_rd, 32'h0000_7F01);
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
    chk("lh32", last_rd, 32'hFFFF_80FF);

    // Faults, and the same accesses with alignment checking off.
    preload(0, 32'h40, 32'hCAFE_F00D);
    preload(1, 32'h40, 32'hCAFE_F00D);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    chk("lw41_fault", 32'(last_f), 32'h1);
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h43, 32'h1234);
    chk("sh43_fault", 32'(last_f), 32'h1);
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    chk("size3_fault", 32'(last_f), 32'h1);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    chk("noalign_lw41", last_rd, 32'hCAFE_F00D);
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h43, 32'h0);
    chk("noalign_lh43", last_rd, 32'hFFFF_CAFE);

    // Reset during the read phase of a halfword store.
    preload(0, 32'h50, 32'h1234_5678);
    @(negedge clk);
    sel = 1'b0; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h0000_BEEF; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);
    chk("rst_mid_read_we", 32'(we0), 32'h0);
    chk("rst_mid_read_addr", ma0, 32'h50);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(rdy0), 32'h0);
    chk("rst_mid_we", 32'(we0), 32'h0);
    chk("rst_mid_addr", ma0, 32'h0);
    bad = 0;
    repeat (2) begin @(negedge clk); if (we0 || rv0) bad++; end
    reset = 1'b0;
    #1 chk("rst_mid_release_ready", 32'(rdy0), 32'h1);
    repeat (4) begin @(negedge clk); if (we0 || rv0) bad++; end
    chk("rst_mid_no_activity", 32'(bad), 32'h0);
    chk("rst_mid_mem", mem0[20], 32'h1234_5678);

    // Back-to-back word loads with req_valid held high.
    preload(0, 32'h60, 32'hA1A2_A3A4);
    preload(0, 32'h64, 32'hB1B2_B3B4);
    preload(0, 32'h68, 32'hC1C2_C3C4);
    @(negedge clk);
    sel = 1'b0; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h60; v0 = 1'b1;
    acc = 0; nresp = 0; nrdy = 0;
    for (int i = 0; i < 3; i++) begin rt[i] = 0; rdat[i] = '0; end
    for (int c = 0; c < 20; c++) begin
      #1;
      take = rdy0 && v0;
      if (take) nrdy++;
      if (rv0) begin
        if (nresp < 3) begin rt[nresp] = c; rdat[nresp] = rd0; end
        nresp++;
      end
      @(posedge clk);
      #1;
      if (take) begin
        acc++;
        if (acc == 3) v0 = 1'b0;
        else req_addr = 32'h60 + 32'(4 * acc);
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(nrdy), 32'h3);
    chk("b2b_resps", 32'(nresp), 32'h3);
    chk("b2b_first_lat", 32'(rt[0]), 32'h2);
    chk("b2b_gap01", 32'(rt[1] - rt[0]), 32'h3);
    chk("b2b_gap12", 32'(rt[2] - rt[1]), 32'h3);
    for (int i = 0; i < 3; i++) chk("b2b_data", rdat[i], ref_mem[0][24 + i]);

    // Random traffic on a small window for both units.
    for (int k = 0; k < 16; k++) begin
      preload(0, 32'h100 + 32'(4 * k), $urandom);
      preload(1, 32'h100 + 32'(4 * k), $urandom);
    end
    for (int k = 0; k < 60; k++)
      do_req(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom),
             32'h100 + 32'($urandom_range(0, 63)), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
